bakery_scheduler: RTL and testbench
===================================

Name: bakery_scheduler

Overview:
- Fairness-enforcing process selector that sits directly upstream of the bakery mutual-exclusion model. It drives that model's select and pause inputs.
- It takes free (nondeterministic) select/pause choices and passes them through. It overrides a choice only when a process has gone unscheduled for MAXWAIT cycles, or when pause has been asserted for PAUSEMAX consecutive cycles.
- This turns unconstrained interleaving into bounded-fair interleaving, so liveness checks do not need external fairness constraints.

Parameters:
- HIPROC, 1, highest process index; indices start at 0.
- SELMSB, 1, MSB of select; must be able to represent HIPROC+1.
- WMSB, 2, MSB of each per-process wait counter and of the pause counter.
- MAXWAIT, 3, starvation bound in enabled cycles; must be >= 1 and <= 2**(WMSB+1)-1.
- PAUSEMAX, 2, maximum consecutive pause cycles; must be >= 1.

Ports:
- clock, input, 1, single clock; all state updates on posedge.
- reset_n, input, 1, asynchronous active-low reset.
- enable, input, 1, advance the scheduler this cycle.
- nd_select, input, SELMSB+1, free process choice.
- nd_pause, input, 1, free pause choice.
- select, output, SELMSB+1, registered process grant; connects to the bakery select input.
- pause, output, 1, registered pause; connects to the bakery pause input.
- forced, output, 1, registered flag: the current select came from starvation override.
- valid, output, 1, high once the first enabled cycle after reset has completed.

Behaviour:
- Reset (reset_n low, takes effect immediately, no clock needed):
  - select=0, pause=0, forced=0, valid=0.
  - All wait[i]=0, pause_cnt=0, FSM state=S_IDLE.
- FSM states:
  - S_IDLE: after reset; goes to S_RUN on the first edge with enable=1.
  - S_RUN: goes to S_HOLD on an edge with enable=0.
  - S_HOLD: returns to S_RUN on an edge with enable=1.
  - valid goes to 1 on the S_IDLE->S_RUN edge and stays 1 until reset.
- Enabled edge (enable=1):
  - cand = nd_select if nd_select <= HIPROC, else 0.
  - starved = set of i with wait[i] == MAXWAIT.
  - If starved is non-empty: grant = lowest index in starved, forced<=1. Otherwise grant=cand, forced<=0.
  - select<=grant; wait[grant]<=0.
  - For every other i: wait[i]<=min(wait[i]+1, MAXWAIT) (saturating, never wraps).
  - If pause_cnt == PAUSEMAX: pause<=0, pause_cnt<=0 (forced progress). Otherwise pause<=nd_pause, and pause_cnt<=nd_pause ? pause_cnt+1 : 0.
- Disabled edge (enable=0): all outputs, counters and valid hold; the only change is the FSM transition to S_HOLD.
- Latency: one cycle from nd_* to outputs. The bakery samples select/pause on the following edge, which adds one more cycle; this is intended.
- Simultaneous starvation: the lowest index wins. Other starved processes stay saturated and are served on later enabled cycles in ascending index order.
- Reset asserted mid-operation discards all history; the sequence restarts from S_IDLE.

Optional Feature:
- Macro: BAKERY_SCHED_LFSR_EN.
- Defined:
  - An internal 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1; advances only on enabled edges) supplies cand and the pause choice.
  - LFSR bits [SELMSB:0] are used as nd_select and bit 15 as nd_pause.
  - The nd_select/nd_pause ports remain present but are ignored.
  - Used for simulation runs without a random testbench.
- Undefined: no LFSR logic; the ports are used directly. This is the formal-verification build.

Decomposition:
- Package bakery_pkg holds:
  - the loc enum shared with the bakery model;
  - the scheduler state enum sched_st {S_IDLE, S_RUN, S_HOLD};
  - default HIPROC/SELMSB constants.
- One natural sub-module: sched_wait_ctr, a saturating counter with clear and increment controls and a reached-MAXWAIT output, instantiated HIPROC+1 times.

Test Plan (defaults unless noted):
1. Reset: drive enable=1 for 5 cycles, then pull reset_n low between edges -> select=0, pause=0, forced=0, valid=0 immediately; after release, the first enabled edge gives valid=1.
2. Starvation override: nd_select=0 every cycle, nd_pause=0 -> select 0,0,0,1 with forced 0,0,0,1, then the pattern repeats.
3. Out-of-range choice: nd_select=3 (above HIPROC=1) -> select=0, forced=0.
4. Pause bound: nd_pause=1 held -> pause 1,1,0,1,1,0...
5. Hold: after select=1, drop enable for 4 cycles while varying nd_* -> select, pause and counters unchanged; the FSM reads S_HOLD.
6. Tie: HIPROC=2, nd_select=0 held -> processes 1 and 2 both reach MAXWAIT together; select goes 1 (forced), then 2 (forced), then 0.

Source files
------------

// File: rtl/bakery_pkg.sv
// rtl/bakery_pkg.sv - shared types and default constants for the bakery model and its scheduler
package bakery_pkg;

  localparam int DEF_HIPROC = 1;
  localparam int DEF_SELMSB = 1;

  typedef enum logic [1:0] {L_IDLE, L_ENTRY, L_WAIT, L_CRIT} loc;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} sched_st;

endpackage

// File: rtl/bakery_scheduler_if.sv
// rtl/bakery_scheduler_if.sv - choice inputs and grant outputs of the bakery scheduler
interface bakery_scheduler_if
  import bakery_pkg::*;
#(
  parameter int SELMSB = DEF_SELMSB
);

  logic              enable;
  logic [SELMSB:0]   nd_select;
  logic              nd_pause;
  logic [SELMSB:0]   select;
  logic              pause;
  logic              forced;
  logic              valid;

  modport master (
    output enable, nd_select, nd_pause,
    input  select, pause, forced, valid
  );

  modport slave (
    input  enable, nd_select, nd_pause,
    output select, pause, forced, valid
  );

endinterface

// File: rtl/sched_wait_ctr.sv
// rtl/sched_wait_ctr.sv - saturating per-process wait counter with starvation flag
module sched_wait_ctr #(
  parameter int WMSB    = 2,
  parameter int MAXWAIT = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam logic [WMSB:0] WMAX = (WMSB+1)'(MAXWAIT);

  logic [WMSB:0] cnt;

  // Clear wins over increment; increment stops at MAXWAIT so the count never wraps
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != WMAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_max = (cnt == WMAX);

endmodule

// File: rtl/bakery_scheduler.sv
// rtl/bakery_scheduler.sv - bounded-fair select/pause generator; BAKERY_SCHED_LFSR_EN swaps the choice ports for an internal LFSR
module bakery_scheduler
  import bakery_pkg::*;
#(
  parameter int HIPROC   = DEF_HIPROC,
  parameter int SELMSB   = DEF_SELMSB,
  parameter int WMSB     = 2,
  parameter int MAXWAIT  = 3,
  parameter int PAUSEMAX = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  bakery_scheduler_if.slave  bus
);

  localparam logic [SELMSB:0] HI_SEL = (SELMSB+1)'(HIPROC);
  localparam logic [WMSB:0]   PMAX   = (WMSB+1)'(PAUSEMAX);

  sched_st          state;
  logic [SELMSB:0]  select_q;
  logic             pause_q;
  logic             forced_q;
  logic             valid_q;
  logic [WMSB:0]    pause_cnt;

  logic [SELMSB:0]  src_sel;
  logic             src_pause;
  logic [SELMSB:0]  cand;
  logic [SELMSB:0]  grant;
  logic             starved;
  logic [HIPROC:0]  at_max;

`ifdef BAKERY_SCHED_LFSR_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign src_sel   = lfsr[SELMSB:0];
  assign src_pause = lfsr[15];

  // Free-running choice source, stepped only when the scheduler advances
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= 16'hACE1;
    end else if (bus.enable) begin
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end
`else
  assign src_sel   = bus.nd_select;
  assign src_pause = bus.nd_pause;
`endif

  assign cand = (src_sel <= HI_SEL) ? src_sel : '0;

  // Starvation override: the lowest-index saturated process beats the free choice
  always_comb begin
    grant   = cand;
    starved = 1'b0;
    for (int i = HIPROC; i >= 0; i--) begin
      if (at_max[i]) begin
        grant   = (SELMSB+1)'(i);
        starved = 1'b1;
      end
    end
  end

  for (genvar g = 0; g <= HIPROC; g++) begin : g_wait
    logic hit;
    assign hit = (grant == (SELMSB+1)'(g));
    sched_wait_ctr #(
      .WMSB    (WMSB),
      .MAXWAIT (MAXWAIT)
    ) u_ctr (
      .clock   (clock),
      .reset_n (reset_n),
      .clr     (bus.enable && hit),
      .inc     (bus.enable && !hit),
      .at_max  (at_max[g])
    );
  end

  // Scheduler FSM with registered grant, pause bound and valid flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      select_q  <= '0;
      pause_q   <= 1'b0;
      forced_q  <= 1'b0;
      valid_q   <= 1'b0;
      pause_cnt <= '0;
    end else begin
      case (state)
        S_IDLE:  if (bus.enable)  state <= S_RUN;
        S_RUN:   if (!bus.enable) state <= S_HOLD;
        default: if (bus.enable)  state <= S_RUN;
      endcase
      if (bus.enable) begin
        valid_q  <= 1'b1;
        select_q <= grant;
        forced_q <= starved;
        if (pause_cnt == PMAX) begin
          pause_q   <= 1'b0;
          pause_cnt <= '0;
        end else begin
          pause_q   <= src_pause;
          pause_cnt <= src_pause ? pause_cnt + 1'b1 : '0;
        end
      end
    end
  end

  assign bus.select = select_q;
  assign bus.pause  = pause_q;
  assign bus.forced = forced_q;
  assign bus.valid  = valid_q;

endmodule

// File: tb/tb_bakery_scheduler.sv
// tb/tb_bakery_scheduler.sv - directed and random checks of two scheduler instances against a reference model
module tb_bakery_scheduler;
  import bakery_pkg::*;

  localparam int MAXW = 3;
  localparam int PMAX = 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  bakery_scheduler_if #(.SELMSB(1)) bus_a ();
  bakery_scheduler_if #(.SELMSB(1)) bus_b ();

  bakery_scheduler #(
    .HIPROC(1), .SELMSB(1), .WMSB(2), .MAXWAIT(MAXW), .PAUSEMAX(PMAX)
  ) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(bus_a)
  );

  bakery_scheduler #(
    .HIPROC(2), .SELMSB(1), .WMSB(2), .MAXWAIT(MAXW), .PAUSEMAX(PMAX)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(bus_b)
  );

  always #5 clock = ~clock;

  int      m_hi [2] = '{1, 2};
  int      m_wt [2][3];
  int      m_pc [2];
  int      m_sel[2];
  int      m_p  [2];
  int      m_f  [2];
  int      m_v  [2];
  sched_st m_st [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) m_wt[k][i] = 0;
      m_pc[k] = 0; m_sel[k] = 0; m_p[k] = 0; m_f[k] = 0; m_v[k] = 0;
      m_st[k] = S_IDLE;
    end
  endtask

  task automatic model_edge(input logic en, input int sel, input logic p);
    int cand;
    int g;
    for (int k = 0; k < 2; k++) begin
      if (!en) begin
        if (m_st[k] != S_IDLE) m_st[k] = S_HOLD;
      end else begin
        cand = (sel <= m_hi[k]) ? sel : 0;
        g = -1;
        for (int i = 0; i <= m_hi[k]; i++)
          if (g < 0 && m_wt[k][i] == MAXW) g = i;
        m_f[k] = (g >= 0) ? 1 : 0;
        if (g < 0) g = cand;
        for (int i = 0; i <= m_hi[k]; i++)
          m_wt[k][i] = (i == g) ? 0 : ((m_wt[k][i] + 1 > MAXW) ? MAXW : m_wt[k][i] + 1);
        m_sel[k] = g;
        if (m_pc[k] == PMAX) begin
          m_p[k] = 0; m_pc[k] = 0;
        end else begin
          m_p[k] = int'(p);
          m_pc[k] = p ? m_pc[k] + 1 : 0;
        end
        m_v[k] = 1;
        m_st[k] = S_RUN;
      end
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ":a.select"}, int'(bus_a.select), m_sel[0]);
    check({tag, ":a.pause"},  int'(bus_a.pause),  m_p[0]);
    check({tag, ":a.forced"}, int'(bus_a.forced), m_f[0]);
    check({tag, ":a.valid"},  int'(bus_a.valid),  m_v[0]);
    check({tag, ":a.state"},  int'(dut_a.state),  int'(m_st[0]));
    check({tag, ":b.select"}, int'(bus_b.select), m_sel[1]);
    check({tag, ":b.pause"},  int'(bus_b.pause),  m_p[1]);
    check({tag, ":b.forced"}, int'(bus_b.forced), m_f[1]);
    check({tag, ":b.valid"},  int'(bus_b.valid),  m_v[1]);
    check({tag, ":b.state"},  int'(dut_b.state),  int'(m_st[1]));
  endtask

  task automatic step(input logic en, input int sel, input logic p, input string tag);
    bus_a.enable = en;   bus_b.enable = en;
    bus_a.nd_select = 2'(sel); bus_b.nd_select = 2'(sel);
    bus_a.nd_pause = p;  bus_b.nd_pause = p;
    @(posedge clock);
    #1;
    model_edge(en, sel, p);
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int tie_exp[3];
    int guard;
    tie_exp[0] = 1; tie_exp[1] = 2; tie_exp[2] = 0;

    bus_a.enable = 1'b0; bus_b.enable = 1'b0;
    bus_a.nd_select = '0; bus_b.nd_select = '0;
    bus_a.nd_pause = 1'b0; bus_b.nd_pause = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all("reset");
    reset_n = 1'b1;

    for (int n = 0; n < 5; n++) step(1'b1, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "pre_reset");
    async_reset("mid_reset");
    step(1'b1, 1, 1'b0, "first_valid");

    for (int n = 0; n < 8; n++) step(1'b1, 0, 1'b0, "starve");
    for (int n = 0; n < 3; n++) step(1'b1, 3, 1'b0, "out_of_range");
    for (int n = 0; n < 6; n++) step(1'b1, int'($urandom_range(0, 3)), 1'b1, "pause_bound");

    guard = 0;
    while (bus_a.select !== 2'd1 && guard < 8) begin
      step(1'b1, 0, 1'b0, "seek_sel1");
      guard++;
    end
    check("seek_sel1_bound", int'(bus_a.select), 1);
    for (int n = 0; n < 4; n++) step(1'b0, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "hold");
    step(1'b1, 0, 1'b0, "resume");

    async_reset("tie_reset");
    for (int n = 0; n < 3; n++) step(1'b1, 0, 1'b0, "tie_fill");
    for (int n = 0; n < 3; n++) begin
      step(1'b1, 0, 1'b0, "tie");
      check("tie_order", int'(bus_b.select), tie_exp[n]);
    end

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) async_reset("rand_reset");
      else step(1'($urandom_range(0, 7) != 0), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
